// File: rtl/iob2axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iob2axil_pkg
//  Description : Shared definitions for the IOb-to-AXI4-Lite master bridge:
//                3-bit FSM state encoding, AXI response codes and a helper
//                that classifies a response as an error.
//  Revision    : 1.0 - initial release
// ============================================================================
package iob2axil_pkg;

    // Bridge FSM state encoding (3-bit).
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_WR_ADDR_DATA = 3'd1,
        ST_WR_RESP      = 3'd2,
        ST_RD_ADDR      = 3'd3,
        ST_RD_DATA      = 3'd4
    } state_t;

    // AXI response codes.
    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_exokay = 2'b01;
    localparam logic [1:0] c_resp_slverr = 2'b10;
    localparam logic [1:0] c_resp_decerr = 2'b11;

    // Anything other than OKAY counts as an error for the sticky flag.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != c_resp_okay);
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob2axil_iob_reg.sv
`default_nettype none
// ============================================================================
//  Module      : iob2axil_iob_reg
//  Description : Generic enabled register with synchronous reset. The i_arst
//                input is honoured synchronously as well; the bridge ties it
//                to 0 and resets through i_rst.
//  Ports       : i_clk, i_arst, i_rst, i_en, i_d[DATA_W] -> o_q[DATA_W]
//  Revision    : 1.0 - initial release
// ============================================================================
module iob2axil_iob_reg #(
    parameter int                DATA_W  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_arst) begin
            r_q <= RST_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/iob2axil.sv
`default_nettype none
// ============================================================================
//  Module      : iob2axil
//  Description : IOb-slave to AXI4-Lite-master bridge. Accepts one IOb
//                request at a time and replays it as a single AXI4-Lite
//                write (AW+W then B) or read (AR then R). Writes produce no
//                IOb response; reads return a one-cycle rvalid_o pulse.
//  Ports       : clk_i, rst_i (sync, active-high)
//                IOb  : valid_i, addr_i, wdata_i, wstrb_i -> ready_o,
//                       rdata_o, rvalid_o
//                AXIL : AW, W, B, AR, R channels (master side)
//                err_o: sticky response error (only with IOB2AXIL_ERR_EN)
//  Options     : `define IOB2AXIL_ERR_EN to add err_o
//  Revision    : 1.0 - initial release
// ============================================================================
module iob2axil
    import iob2axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    // IOb slave
    input  logic                valid_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic                ready_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rvalid_o,
    // AXI4-Lite master
    output logic [ADDR_W-1:0]   axil_awaddr_o,
    output logic [2:0]          axil_awprot_o,
    output logic                axil_awvalid_o,
    input  logic                axil_awready_i,
    output logic [DATA_W-1:0]   axil_wdata_o,
    output logic [DATA_W/8-1:0] axil_wstrb_o,
    output logic                axil_wvalid_o,
    input  logic                axil_wready_i,
    input  logic [1:0]          axil_bresp_i,
    input  logic                axil_bvalid_i,
    output logic                axil_bready_o,
    output logic [ADDR_W-1:0]   axil_araddr_o,
    output logic [2:0]          axil_arprot_o,
    output logic                axil_arvalid_o,
    input  logic                axil_arready_i,
    input  logic [DATA_W-1:0]   axil_rdata_i,
    input  logic [1:0]          axil_rresp_i,
    input  logic                axil_rvalid_i,
`ifdef IOB2AXIL_ERR_EN
    output logic                err_o,
`endif
    output logic                axil_rready_o
);

    state_t r_state;
    logic   r_aw_pend;
    logic   r_w_pend;
    logic   r_arvalid;
    logic   r_bready;
    logic   r_rready;

    logic   w_accept;
    logic   w_aw_hs;
    logic   w_w_hs;
    logic   w_b_hs;
    logic   w_ar_hs;
    logic   w_r_hs;
    logic   w_aw_done;
    logic   w_w_done;

    logic [ADDR_W-1:0]   w_addr_q;
    logic [DATA_W-1:0]   w_wdata_q;
    logic [DATA_W/8-1:0] w_wstrb_q;

    assign w_accept  = valid_i && (r_state == ST_IDLE);
    assign w_aw_hs   = r_aw_pend && axil_awready_i;
    assign w_w_hs    = r_w_pend  && axil_wready_i;
    assign w_b_hs    = r_bready  && axil_bvalid_i;
    assign w_ar_hs   = r_arvalid && axil_arready_i;
    assign w_r_hs    = r_rready  && axil_rvalid_i;
    // A channel is done if it already handshook or handshakes this cycle.
    assign w_aw_done = !r_aw_pend || w_aw_hs;
    assign w_w_done  = !r_w_pend  || w_w_hs;

    // ------------------------------------------------------------------------
    // Control FSM. Valid/ready outputs are registers set on state entry and
    // cleared on their own handshake, so they never drop without one.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_aw_pend <= 1'b0;
            r_w_pend  <= 1'b0;
            r_arvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (|wstrb_i) begin
                            r_state   <= ST_WR_ADDR_DATA;
                            r_aw_pend <= 1'b1;
                            r_w_pend  <= 1'b1;
                        end else begin
                            r_state   <= ST_RD_ADDR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                ST_WR_ADDR_DATA: begin
                    if (w_aw_hs) begin
                        r_aw_pend <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_w_pend <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_state  <= ST_WR_RESP;
                        r_bready <= 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (axil_bvalid_i) begin
                        r_state  <= ST_IDLE;
                        r_bready <= 1'b0;
                    end
                end
                ST_RD_ADDR: begin
                    if (axil_arready_i) begin
                        r_state   <= ST_RD_DATA;
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (axil_rvalid_i) begin
                        r_state  <= ST_IDLE;
                        r_rready <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_aw_pend <= 1'b0;
                    r_w_pend  <= 1'b0;
                    r_arvalid <= 1'b0;
                    r_bready  <= 1'b0;
                    r_rready  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    iob2axil_iob_reg #(.DATA_W(ADDR_W)) u_reg_addr (
        .i_clk (clk_i), .i_arst (1'b0), .i_rst (rst_i),
        .i_en  (w_accept), .i_d (addr_i), .o_q (w_addr_q)
    );

    iob2axil_iob_reg #(.DATA_W(DATA_W)) u_reg_wdata (
        .i_clk (clk_i), .i_arst (1'b0), .i_rst (rst_i),
        .i_en  (w_accept), .i_d (wdata_i), .o_q (w_wdata_q)
    );

    iob2axil_iob_reg #(.DATA_W(DATA_W/8)) u_reg_wstrb (
        .i_clk (clk_i), .i_arst (1'b0), .i_rst (rst_i),
        .i_en  (w_accept), .i_d (wstrb_i), .o_q (w_wstrb_q)
    );

    // Read data is captured regardless of rresp.
    iob2axil_iob_reg #(.DATA_W(DATA_W)) u_reg_rdata (
        .i_clk (clk_i), .i_arst (1'b0), .i_rst (rst_i),
        .i_en  (w_r_hs), .i_d (axil_rdata_i), .o_q (rdata_o)
    );

    iob2axil_iob_reg #(.DATA_W(1)) u_reg_rvalid (
        .i_clk (clk_i), .i_arst (1'b0), .i_rst (rst_i),
        .i_en  (1'b1), .i_d (w_r_hs), .o_q (rvalid_o)
    );

`ifdef IOB2AXIL_ERR_EN
    // Sticky: loads a constant 1 whenever a non-OKAY response handshakes.
    logic w_err_set;
    assign w_err_set = (w_b_hs && resp_is_err(axil_bresp_i)) ||
                       (w_r_hs && resp_is_err(axil_rresp_i));

    iob2axil_iob_reg #(.DATA_W(1)) u_reg_err (
        .i_clk (clk_i), .i_arst (1'b0), .i_rst (rst_i),
        .i_en  (w_err_set), .i_d (1'b1), .o_q (err_o)
    );
`else
    // Responses do not affect flow; without error tracking they are dropped.
    logic w_unused_resp;
    assign w_unused_resp = ^{axil_bresp_i, axil_rresp_i, w_b_hs};
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ready_o        = (r_state == ST_IDLE);
    assign axil_awaddr_o  = w_addr_q;
    assign axil_araddr_o  = w_addr_q;
    assign axil_wdata_o   = w_wdata_q;
    assign axil_wstrb_o   = w_wstrb_q;
    assign axil_awvalid_o = r_aw_pend;
    assign axil_wvalid_o  = r_w_pend;
    assign axil_arvalid_o = r_arvalid;
    assign axil_bready_o  = r_bready;
    assign axil_rready_o  = r_rready;
    assign axil_awprot_o  = 3'b000;
    assign axil_arprot_o  = 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_iob2axil.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iob2axil
//  Description : Directed self-checking bench for iob2axil. Inputs change and
//                outputs are sampled 1 time unit after each rising edge.
//                Error-flag steps are included when IOB2AXIL_ERR_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iob2axil;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic        ready_o;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic [31:0] axil_awaddr_o;
    logic [2:0]  axil_awprot_o;
    logic        axil_awvalid_o;
    logic        axil_awready_i;
    logic [31:0] axil_wdata_o;
    logic [3:0]  axil_wstrb_o;
    logic        axil_wvalid_o;
    logic        axil_wready_i;
    logic [1:0]  axil_bresp_i;
    logic        axil_bvalid_i;
    logic        axil_bready_o;
    logic [31:0] axil_araddr_o;
    logic [2:0]  axil_arprot_o;
    logic        axil_arvalid_o;
    logic        axil_arready_i;
    logic [31:0] axil_rdata_i;
    logic [1:0]  axil_rresp_i;
    logic        axil_rvalid_i;
    logic        axil_rready_o;
`ifdef IOB2AXIL_ERR_EN
    logic        err_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    iob2axil #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .wstrb_i        (wstrb_i),
        .ready_o        (ready_o),
        .rdata_o        (rdata_o),
        .rvalid_o       (rvalid_o),
        .axil_awaddr_o  (axil_awaddr_o),
        .axil_awprot_o  (axil_awprot_o),
        .axil_awvalid_o (axil_awvalid_o),
        .axil_awready_i (axil_awready_i),
        .axil_wdata_o   (axil_wdata_o),
        .axil_wstrb_o   (axil_wstrb_o),
        .axil_wvalid_o  (axil_wvalid_o),
        .axil_wready_i  (axil_wready_i),
        .axil_bresp_i   (axil_bresp_i),
        .axil_bvalid_i  (axil_bvalid_i),
        .axil_bready_o  (axil_bready_o),
        .axil_araddr_o  (axil_araddr_o),
        .axil_arprot_o  (axil_arprot_o),
        .axil_arvalid_o (axil_arvalid_o),
        .axil_arready_i (axil_arready_i),
        .axil_rdata_i   (axil_rdata_i),
        .axil_rresp_i   (axil_rresp_i),
        .axil_rvalid_i  (axil_rvalid_i),
`ifdef IOB2AXIL_ERR_EN
        .err_o          (err_o),
`endif
        .axil_rready_o  (axil_rready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Valid/ready summary: {awvalid, wvalid, bready, arvalid, rready}
    function automatic logic [4:0] hs();
        return {axil_awvalid_o, axil_wvalid_o, axil_bready_o, axil_arvalid_o, axil_rready_o};
    endfunction

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; addr_i = '0; wdata_i = '0; wstrb_i = '0;
        axil_awready_i = 1'b0; axil_wready_i = 1'b0; axil_bresp_i = 2'b00;
        axil_bvalid_i = 1'b0; axil_arready_i = 1'b0; axil_rdata_i = '0;
        axil_rresp_i = 2'b00; axil_rvalid_i = 1'b0;
        tick(); tick();
        rst_i = 1'b0;

        // ---------------- reset state ----------------
        chk("rst_ready",  ready_o, 1);
        chk("rst_hs",     hs(), 5'b00000);
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata",  rdata_o, 0);
        chk("rst_awaddr", axil_awaddr_o, 0);
        chk("rst_wdata",  axil_wdata_o, 0);
        chk("rst_wstrb",  axil_wstrb_o, 0);
        chk("rst_prot",   {axil_awprot_o, axil_arprot_o}, 0);
`ifdef IOB2AXIL_ERR_EN
        chk("rst_err",    err_o, 0);
`endif

        // ---------------- best-case write ----------------
        valid_i = 1; addr_i = 32'h40; wdata_i = 32'hDEADBEEF; wstrb_i = 4'hF;
        tick();                                   // cycle 1
        valid_i = 0; addr_i = '0; wdata_i = '0; wstrb_i = '0;
        chk("w1_hs_c1",   hs(), 5'b11000);
        chk("w1_awaddr",  axil_awaddr_o, 32'h40);
        chk("w1_wdata",   axil_wdata_o, 32'hDEADBEEF);
        chk("w1_wstrb",   axil_wstrb_o, 4'hF);
        chk("w1_ready_c1", ready_o, 0);
        axil_awready_i = 1; axil_wready_i = 1;
        tick();                                   // cycle 2
        axil_awready_i = 0; axil_wready_i = 0;
        chk("w1_hs_c2",   hs(), 5'b00100);
        axil_bvalid_i = 1;
        tick();                                   // cycle 3
        axil_bvalid_i = 0;
        chk("w1_ready_c3", ready_o, 1);
        chk("w1_hs_c3",   hs(), 5'b00000);
        chk("w1_rvalid",  rvalid_o, 0);

        // ---------------- write, wready 3 cycles before awready ----------------
        valid_i = 1; addr_i = 32'h44; wdata_i = 32'hCAFEF00D; wstrb_i = 4'h3;
        tick();                                   // cycle 1
        valid_i = 0; addr_i = 32'hFFFF_FFFF; wstrb_i = '0;
        chk("w2_hs_c1", hs(), 5'b11000);
        axil_wready_i = 1;
        tick();                                   // cycle 2
        axil_wready_i = 0;
        chk("w2_hs_c2",   hs(), 5'b10000);
        chk("w2_awaddr2", axil_awaddr_o, 32'h44);
        tick();                                   // cycle 3
        chk("w2_hs_c3",   hs(), 5'b10000);
        chk("w2_awaddr3", axil_awaddr_o, 32'h44);
        tick();                                   // cycle 4
        chk("w2_hs_c4",   hs(), 5'b10000);
        chk("w2_wstrb",   axil_wstrb_o, 4'h3);
        axil_awready_i = 1;
        tick();                                   // cycle 5
        axil_awready_i = 0;
        chk("w2_hs_c5",   hs(), 5'b00100);
        axil_bvalid_i = 1; axil_bresp_i = 2'b10; // non-OKAY: flow unaffected
        tick();                                   // cycle 6
        axil_bvalid_i = 0; axil_bresp_i = 2'b00;
        chk("w2_ready_c6", ready_o, 1);
        chk("w2_hs_c6",   hs(), 5'b00000);

        // ---------------- read, arready delayed 2 cycles ----------------
        valid_i = 1; addr_i = 32'h80; wstrb_i = 4'h0;
        tick();                                   // cycle 1
        valid_i = 0; addr_i = '0;
        chk("r1_hs_c1",   hs(), 5'b00010);
        chk("r1_araddr1", axil_araddr_o, 32'h80);
        tick();                                   // cycle 2
        chk("r1_hs_c2",   hs(), 5'b00010);
        chk("r1_araddr2", axil_araddr_o, 32'h80);
        tick();                                   // cycle 3
        chk("r1_araddr3", axil_araddr_o, 32'h80);
        axil_arready_i = 1;
        tick();                                   // cycle 4
        axil_arready_i = 0;
        chk("r1_hs_c4",   hs(), 5'b00001);
        chk("r1_ready_c4", ready_o, 0);
        axil_rvalid_i = 1; axil_rdata_i = 32'h12345678;
        tick();                                   // cycle 5
        axil_rvalid_i = 0; axil_rdata_i = 32'hFFFF_0000;
        chk("r1_rvalid_c5", rvalid_o, 1);
        chk("r1_rdata",     rdata_o, 32'h12345678);
        chk("r1_ready_c5",  ready_o, 1);
        tick();                                   // cycle 6
        chk("r1_rvalid_c6", rvalid_o, 0);

        // ---------------- back-to-back read then write, valid held ----------------
        valid_i = 1; addr_i = 32'h84; wstrb_i = 4'h0;
        tick();                                   // cycle 1: read in RD_ADDR
        addr_i = 32'h88; wdata_i = 32'h0BADF00D; wstrb_i = 4'hC;
        chk("bb_ready_c1",  ready_o, 0);
        chk("bb_araddr",    axil_araddr_o, 32'h84);
        axil_arready_i = 1;
        tick();                                   // cycle 2: RD_DATA
        axil_arready_i = 0;
        chk("bb_hs_c2",     hs(), 5'b00001);
        axil_rvalid_i = 1; axil_rdata_i = 32'hA5A5A5A5;
        tick();                                   // cycle 3: rvalid_o pulse, accept write
        axil_rvalid_i = 0;
        chk("bb_rvalid_c3", rvalid_o, 1);
        chk("bb_rdata",     rdata_o, 32'hA5A5A5A5);
        chk("bb_ready_c3",  ready_o, 1);
        chk("bb_noaw_c3",   axil_awvalid_o, 0);
        tick();                                   // cycle 4: write issued
        valid_i = 0; wstrb_i = '0;
        chk("bb_hs_c4",     hs(), 5'b11000);
        chk("bb_awaddr",    axil_awaddr_o, 32'h88);
        chk("bb_wdata",     axil_wdata_o, 32'h0BADF00D);
        chk("bb_wstrb",     axil_wstrb_o, 4'hC);
        chk("bb_rvalid_c4", rvalid_o, 0);
        axil_awready_i = 1; axil_wready_i = 1;
        tick();
        axil_awready_i = 0; axil_wready_i = 0;
        axil_bvalid_i = 1;
        tick();
        axil_bvalid_i = 0;
        chk("bb_ready_end", ready_o, 1);

        // ---------------- reset during WR_RESP ----------------
        valid_i = 1; addr_i = 32'h90; wdata_i = 32'h11112222; wstrb_i = 4'h1;
        tick();                                   // cycle 1
        valid_i = 0; wstrb_i = '0;
        axil_awready_i = 1; axil_wready_i = 1;
        tick();                                   // cycle 2: WR_RESP
        axil_awready_i = 0; axil_wready_i = 0;
        chk("rs_hs_c2", hs(), 5'b00100);
        rst_i = 1;
        tick();                                   // cycle 3
        rst_i = 0;
        chk("rs_hs_c3",    hs(), 5'b00000);
        chk("rs_ready_c3", ready_o, 1);
        chk("rs_awaddr",   axil_awaddr_o, 0);
        valid_i = 1; addr_i = 32'h94; wstrb_i = 4'h0;
        tick();
        valid_i = 0;
        chk("rs_rd_hs1",   hs(), 5'b00010);
        chk("rs_rd_addr",  axil_araddr_o, 32'h94);
        axil_arready_i = 1;
        tick();
        axil_arready_i = 0;
        axil_rvalid_i = 1; axil_rdata_i = 32'h55AA55AA;
        tick();
        axil_rvalid_i = 0;
        chk("rs_rd_rvalid", rvalid_o, 1);
        chk("rs_rd_rdata",  rdata_o, 32'h55AA55AA);

`ifdef IOB2AXIL_ERR_EN
        // ---------------- sticky error flag ----------------
        tick();
        valid_i = 1; addr_i = 32'hA0; wstrb_i = 4'h0;
        tick();
        valid_i = 0;
        axil_arready_i = 1;
        tick();
        axil_arready_i = 0;
        axil_rvalid_i = 1; axil_rresp_i = 2'b10; axil_rdata_i = 32'h0000BEEF;
        chk("er_err_before", err_o, 0);
        tick();
        axil_rvalid_i = 0; axil_rresp_i = 2'b00;
        chk("er_err_set",   err_o, 1);
        chk("er_rdata",     rdata_o, 32'h0000BEEF);
        // OKAY write afterwards leaves the flag set
        valid_i = 1; addr_i = 32'hA4; wdata_i = 32'h1; wstrb_i = 4'hF;
        tick();
        valid_i = 0; wstrb_i = '0;
        axil_awready_i = 1; axil_wready_i = 1;
        tick();
        axil_awready_i = 0; axil_wready_i = 0;
        axil_bvalid_i = 1;
        tick();
        axil_bvalid_i = 0;
        chk("er_err_held", err_o, 1);
        rst_i = 1;
        tick();
        rst_i = 0;
        chk("er_err_clr",  err_o, 0);
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
